adc_err_encoder: RTL and testbench

Sampling front-end of the digital loop: on each falling edge of the frame divider's `convst_bar` it runs one handshake with the external parallel ADC (BUSY, CS#, RD#). It then converts the sample into a saturated signed error `vref - sample` for the compensator. The error is registered and held stable for the whole frame, so the compensator can latch it on its `clk_comp` strobe late in the same 64-cycle frame.

---
 rtl/adc_err_encoder_pkg.sv | 29 ++
 rtl/adc_err_encoder_if.sv | 23 ++
 rtl/adc_err_sat.sv | 22 ++
 rtl/adc_err_encoder.sv | 131 +++++++++++++
 tb/tb_adc_err_encoder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/adc_err_encoder_pkg.sv
// Shared types and helpers for the ADC sampling front-end.
package adc_enc_pkg;

  localparam int unsigned AdcWDef = 8;
  localparam int unsigned ErrWDef = 5;

  typedef enum logic [2:0] {
    StIdle,
    StWaitHi,
    StWaitLo,
    StRead,
    StCalc
  } state_e;

  // Clamp a signed difference into the two's complement range of err_w bits.
  function automatic int sat_err(input int diff, input int unsigned err_w);
    int hi;
    int lo;
    hi = (1 << (err_w - 1)) - 1;
    lo = -hi - 1;
    if (diff > hi) begin
      return hi;
    end else if (diff < lo) begin
      return lo;
    end
    return diff;
  endfunction

endpackage

// File: rtl/adc_err_encoder_if.sv
// Parallel ADC handshake: BUSY in, CS#/RD# out, data bus in.
interface adc_err_encoder_if #(
  parameter int unsigned ADC_W = adc_enc_pkg::AdcWDef
);
  logic             adc_busy;
  logic [ADC_W-1:0] adc_data;
  logic             adc_cs_bar;
  logic             adc_rd_bar;

  modport master (
    output adc_cs_bar,
    output adc_rd_bar,
    input  adc_busy,
    input  adc_data
  );

  modport slave (
    input  adc_cs_bar,
    input  adc_rd_bar,
    output adc_busy,
    output adc_data
  );
endinterface

// File: rtl/adc_err_sat.sv
// Combinational setpoint error: vref - sample, clamped to ERR_W signed bits.
module adc_err_sat
  import adc_enc_pkg::*;
#(
  parameter int unsigned ADC_W = AdcWDef,
  parameter int unsigned ERR_W = ErrWDef
) (
  input  logic [ADC_W-1:0] vref,
  input  logic [ADC_W-1:0] sample,
  output logic [ERR_W-1:0] err
);

  logic signed [ADC_W:0] diff;
  int                    sat;

  always_comb begin
    diff = $signed({1'b0, vref}) - $signed({1'b0, sample});
    sat  = sat_err(int'(diff), ERR_W);
    err  = ERR_W'(sat);
  end

endmodule

// File: rtl/adc_err_encoder.sv
// One ADC handshake per convst_bar falling edge; emits a saturated error held for the frame.
module adc_err_encoder
  import adc_enc_pkg::*;
#(
  parameter int unsigned ADC_W      = AdcWDef,
  parameter int unsigned ERR_W      = ErrWDef,
  parameter int unsigned RD_CYCLES  = 2,
  parameter int unsigned TMO_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                convst_bar,
  input  logic [ADC_W-1:0]    vref,
  adc_err_encoder_if.master   adc,
  output logic [ERR_W-1:0]    err,
  output logic                err_valid,
  output logic                tmo_flag
);

  localparam int unsigned TmrMax = (TMO_CYCLES > RD_CYCLES) ? TMO_CYCLES : RD_CYCLES;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam logic [TmrW-1:0] TmoLast = TmrW'(TMO_CYCLES - 1);
  localparam logic [TmrW-1:0] RdLast  = TmrW'(RD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              cv_q;
  logic              start;
  logic              capture;
  logic              tmo_set;
  logic [ADC_W-1:0]  sample_q;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  sat_out;
  logic              err_valid_q;
  logic              tmo_q;
  logic              cs_q;

  assign start = cv_q & ~convst_bar;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    capture = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      StIdle: begin
        tmr_d = tmr_q;
        if (start) begin
          state_d = StWaitHi;
          tmr_d   = '0;
        end
      end
      StWaitHi: begin
        if (adc.adc_busy) begin
          state_d = StWaitLo;
          tmr_d   = '0;
        end else if (tmr_q == TmoLast) begin
          state_d = StIdle;
          tmo_set = 1'b1;
        end
      end
      StWaitLo: begin
        if (!adc.adc_busy) begin
          state_d = StRead;
          tmr_d   = '0;
        end else if (tmr_q == TmoLast) begin
          state_d = StIdle;
          tmo_set = 1'b1;
        end
      end
      StRead: begin
        if (tmr_q == RdLast) begin
          state_d = StCalc;
          capture = 1'b1;
        end
      end
      StCalc: begin
        tmr_d   = tmr_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  adc_err_sat #(
    .ADC_W (ADC_W),
    .ERR_W (ERR_W)
  ) u_sat (
    .vref   (vref),
    .sample (sample_q),
    .err    (sat_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      cv_q        <= 1'b0;
      sample_q    <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      tmo_q       <= 1'b0;
      cs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cv_q        <= convst_bar;
      err_valid_q <= (state_q == StCalc);
      // Strobes registered from next state so the ADC sees glitch-free CS#/RD#.
      cs_q        <= (state_d != StRead);
      if (capture) begin
        sample_q <= adc.adc_data;
      end
      if (state_q == StCalc) begin
        err_q <= sat_out;
      end
      if (tmo_set) begin
        tmo_q <= 1'b1;
      end
    end
  end

  assign adc.adc_cs_bar = cs_q;
  assign adc.adc_rd_bar = cs_q;
  assign err            = err_q;
  assign err_valid      = err_valid_q;
  assign tmo_flag       = tmo_q;

endmodule

// File: tb/tb_adc_err_encoder.sv
// Directed bench for adc_err_encoder: table of sample/vref frames plus timeout and reset sequences.
module tb_adc_err_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       convst_bar;
  logic [7:0] vref;
  logic [4:0] err;
  logic       err_valid;
  logic       tmo_flag;

  adc_err_encoder_if #(.ADC_W(8)) adc ();

  adc_err_encoder #(
    .ADC_W      (8),
    .ERR_W      (5),
    .RD_CYCLES  (2),
    .TMO_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .convst_bar (convst_bar),
    .vref       (vref),
    .adc        (adc.master),
    .err        (err),
    .err_valid  (err_valid),
    .tmo_flag   (tmo_flag)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int cs_lo  = 0;
  int rd_lo  = 0;
  int ev_cnt = 0;
  int ev_cyc = 0;
  int ev_err = 0;
  int n_pass = 0;
  int n_tot  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!adc.adc_cs_bar) cs_lo <= cs_lo + 1;
    if (!adc.adc_rd_bar) rd_lo <= rd_lo + 1;
    if (err_valid) begin
      ev_cnt <= ev_cnt + 1;
      ev_cyc <= cyc;
      ev_err <= int'($signed(err));
    end
  end

  typedef struct {
    logic [7:0] vref;
    logic [7:0] data;
    int         exp;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Produce a convst_bar falling edge; returns in cycle T0 (start asserted).
  task automatic frame_edge();
    convst_bar = 1'b1;
    step();
    convst_bar = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] v, input logic [7:0] d,
                           input int dly, input int len, input bit extra, input int exp);
    int cs0, rd0, ev0, bf;
    cs0 = cs_lo; rd0 = rd_lo; ev0 = ev_cnt;
    vref = v;
    adc.adc_data = d;
    frame_edge();
    repeat (dly) step();
    adc.adc_busy = 1'b1;
    if (extra) begin
      step();
      convst_bar = 1'b1;
      step();
      convst_bar = 1'b0;
      repeat (len - 2) step();
    end else begin
      repeat (len) step();
    end
    adc.adc_busy = 1'b0;
    bf = cyc;
    repeat (8) step();
    chk({nm, " cs_low_cycles"}, cs_lo - cs0, 2);
    chk({nm, " rd_low_cycles"}, rd_lo - rd0, 2);
    chk({nm, " err_valid_pulses"}, ev_cnt - ev0, 1);
    chk({nm, " busy_to_err_latency"}, ev_cyc - bf, 4);
    chk({nm, " err"}, ev_err, exp);
    chk({nm, " err_held"}, int'($signed(err)), exp);
  endtask

  task automatic run_timeout(input string nm, input int dly, input int len, input int prev);
    int cs0, ev0;
    cs0 = cs_lo; ev0 = ev_cnt;
    frame_edge();
    repeat (dly) step();
    adc.adc_busy = (len > 0);
    repeat (len) step();
    adc.adc_busy = 1'b0;
    repeat (24) step();
    chk({nm, " cs_low_cycles"}, cs_lo - cs0, 0);
    chk({nm, " err_valid_pulses"}, ev_cnt - ev0, 0);
    chk({nm, " tmo_flag"}, int'(tmo_flag), 1);
    chk({nm, " err_unchanged"}, int'($signed(err)), prev);
  endtask

  initial begin
    int cs0, ev0;
    vecs[0] = '{8'd128, 8'd125,   3};
    vecs[1] = '{8'd128, 8'd60,   15};
    vecs[2] = '{8'd128, 8'd200, -16};
    vecs[3] = '{8'd128, 8'd128,   0};
    vecs[4] = '{8'd128, 8'd113,  15};
    vecs[5] = '{8'd128, 8'd112,  15};
    vecs[6] = '{8'd128, 8'd144, -16};
    vecs[7] = '{8'd128, 8'd145, -16};
    vecs[8] = '{8'd100, 8'd101,  -1};
    vecs[9] = '{8'd255, 8'd0,    15};

    rst = 1'b0;
    convst_bar = 1'b0;
    vref = 8'd128;
    adc.adc_busy = 1'b0;
    adc.adc_data = 8'd0;
    repeat (3) step();
    chk("reset cs_bar", int'(adc.adc_cs_bar), 1);
    chk("reset rd_bar", int'(adc.adc_rd_bar), 1);
    chk("reset err", int'(err), 0);
    chk("reset err_valid", int'(err_valid), 0);
    chk("reset tmo_flag", int'(tmo_flag), 0);

    // convst_bar held low out of reset must not look like an edge.
    cs0 = cs_lo; ev0 = ev_cnt;
    rst = 1'b1;
    repeat (10) step();
    chk("no_start cs_low_cycles", cs_lo - cs0, 0);
    chk("no_start err_valid", ev_cnt - ev0, 0);
    chk("no_start err", int'(err), 0);

    for (int i = 0; i < 10; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].vref, vecs[i].data, 3, 10, 1'b0, vecs[i].exp);
    end

    run_frame("extra_edge", 8'd128, 8'd125, 3, 10, 1'b1, 3);

    run_timeout("tmo_no_busy", 0, 0, 3);
    run_timeout("tmo_late_busy", 17, 5, 3);
    run_timeout("tmo_long_busy", 3, 20, 3);

    run_frame("after_tmo", 8'd128, 8'd120, 14, 5, 1'b0, 8);
    chk("after_tmo tmo_sticky", int'(tmo_flag), 1);

    // Reset asserted while CS#/RD# are low.
    vref = 8'd128;
    adc.adc_data = 8'd100;
    frame_edge();
    repeat (3) step();
    adc.adc_busy = 1'b1;
    repeat (6) step();
    adc.adc_busy = 1'b0;
    step();
    chk("mid_read cs_low", int'(adc.adc_cs_bar), 0);
    ev0 = ev_cnt;
    rst = 1'b0;
    step();
    chk("mid_read rst cs_bar", int'(adc.adc_cs_bar), 1);
    chk("mid_read rst rd_bar", int'(adc.adc_rd_bar), 1);
    chk("mid_read rst err", int'(err), 0);
    chk("mid_read rst tmo_flag", int'(tmo_flag), 0);
    rst = 1'b1;
    repeat (8) step();
    chk("mid_read no_err_valid", ev_cnt - ev0, 0);
    chk("mid_read err_still_zero", int'(err), 0);

    run_frame("post_reset", 8'd128, 8'd125, 3, 10, 1'b0, 3);
    chk("post_reset tmo_flag", int'(tmo_flag), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
